// File: rtl/poly_decompress_if.sv
// Byte-in / coefficient-out valid-ready bundle for the Kyber decompressor.
// master: byte producer + coefficient consumer side; slave: the decompressor.
interface poly_decompress_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] out_coef;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    output in_byte, in_valid, out_ready,
    input  in_ready, out_coef, out_valid, out_last
  );

  modport slave (
    input  in_byte, in_valid, out_ready,
    output in_ready, out_coef, out_valid, out_last
  );
endinterface

// File: rtl/poly_decompress.sv
// Streaming Kyber Decompress_d: unpacks D-bit values from an LSB-first byte stream, emits round(Q*y/2^D).
// Latency: byte accepted at edge k yields its first coefficient on out_valid after edge k+2.
// Backpressure: two-stage pipeline stalls on !out_ready; extraction and byte intake pause behind it.
module poly_decompress #(
  parameter int D = 4,
  parameter int Q = 3329,
  parameter int N = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  poly_decompress_if.slave  bus,
  output logic              busy,
  output logic              done
);

  localparam int NBYTES = N * D / 8;
  localparam int BCW    = $clog2(NBYTES + 1);
  localparam int CCW    = $clog2(N);
  localparam int W      = 12 + D;

  localparam logic [4:0]     D_W      = 5'(D);
  localparam logic [BCW-1:0] NBYTES_W = BCW'(NBYTES);
  localparam logic [CCW-1:0] LAST_IDX = CCW'(N - 1);
  localparam logic [W-1:0]   Q_W      = W'(Q);
  localparam logic [W-1:0]   RND_W    = W'(1) << (D - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [23:0]    buf_q, buf_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [CCW-1:0] ccnt_q, ccnt_d;
  logic           s1_vld_q, s1_vld_d;
  logic [D-1:0]   s1_y_q, s1_y_d;
  logic           s1_last_q, s1_last_d;
  logic           out_vld_q, out_vld_d;
  logic [11:0]    out_coef_q, out_coef_d;
  logic           out_last_q, out_last_d;

  logic           in_ready_w;
  logic           accept;
  logic           s2_load;
  logic           extract;
  logic [W-1:0]   prod;
  logic [11:0]    coef_w;

  // Handshake qualifiers; intake only when the buffer cannot yield a value, so accept/extract never collide.
  always_comb begin
    in_ready_w = (state_q == S_RUN) && (bcnt_q < NBYTES_W) && (cnt_q < D_W);
    accept     = bus.in_valid && in_ready_w;
    s2_load    = !out_vld_q || bus.out_ready;
    extract    = (state_q == S_RUN) && (cnt_q >= D_W) && (!s1_vld_q || s2_load);
  end

  // Rounded scaling at full width; the result of a legal y is always below Q so 12 bits suffice.
  assign prod   = Q_W * W'(s1_y_q) + RND_W;
  assign coef_w = 12'(prod >> D);

  // Next-state logic for the polynomial sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (extract && (ccnt_q == LAST_IDX)) state_d = S_FLUSH;
      S_FLUSH: if (out_vld_q && bus.out_ready && out_last_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bit buffer, byte/coef counters and pipeline next-state.
  always_comb begin
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    bcnt_d     = bcnt_q;
    ccnt_d     = ccnt_q;
    s1_vld_d   = s1_vld_q;
    s1_y_d     = s1_y_q;
    s1_last_d  = s1_last_q;
    out_vld_d  = out_vld_q;
    out_coef_d = out_coef_q;
    out_last_d = out_last_q;

    if ((state_q == S_IDLE) && start) begin
      buf_d  = '0;
      cnt_d  = '0;
      bcnt_d = '0;
      ccnt_d = '0;
    end else if (accept) begin
      buf_d  = buf_q | ({16'd0, bus.in_byte} << cnt_q);
      cnt_d  = cnt_q + 5'd8;
      bcnt_d = bcnt_q + BCW'(1);
    end else if (extract) begin
      buf_d  = buf_q >> D;
      cnt_d  = cnt_q - D_W;
      ccnt_d = ccnt_q + CCW'(1);
    end

    if (extract) begin
      s1_vld_d  = 1'b1;
      s1_y_d    = buf_q[D-1:0];
      s1_last_d = (ccnt_q == LAST_IDX);
    end else if (s2_load) begin
      s1_vld_d  = 1'b0;
    end

    if (s2_load) begin
      out_vld_d  = s1_vld_q;
      out_coef_d = coef_w;
      out_last_d = s1_vld_q && s1_last_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      cnt_q      <= '0;
      bcnt_q     <= '0;
      ccnt_q     <= '0;
      s1_vld_q   <= 1'b0;
      s1_y_q     <= '0;
      s1_last_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_coef_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      ccnt_q     <= ccnt_d;
      s1_vld_q   <= s1_vld_d;
      s1_y_q     <= s1_y_d;
      s1_last_q  <= s1_last_d;
      out_vld_q  <= out_vld_d;
      out_coef_q <= out_coef_d;
      out_last_q <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_coef  = out_coef_q;
  assign bus.out_valid = out_vld_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_poly_decompress.sv
// Directed bench for poly_decompress: one D=4 and one D=10 instance, selected by sel.
module tb_poly_decompress;

  localparam int NC = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sel;
  logic       tb_start;
  logic [7:0] tb_in_byte;
  logic       tb_in_valid;
  logic       tb_out_ready;

  poly_decompress_if if4();
  poly_decompress_if if10();

  logic start4, start10, busy4, busy10, done4, done10;

  assign if4.in_byte    = tb_in_byte;
  assign if4.in_valid   = tb_in_valid & ~sel;
  assign if4.out_ready  = tb_out_ready & ~sel;
  assign start4         = tb_start & ~sel;
  assign if10.in_byte   = tb_in_byte;
  assign if10.in_valid  = tb_in_valid & sel;
  assign if10.out_ready = tb_out_ready & sel;
  assign start10        = tb_start & sel;

  poly_decompress #(.D(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .bus(if4), .busy(busy4), .done(done4)
  );
  poly_decompress #(.D(10)) u_d10 (
    .clk(clk), .rst_n(rst_n), .start(start10), .bus(if10), .busy(busy10), .done(done10)
  );

  logic        o_in_ready, o_out_valid, o_out_last, o_busy, o_done;
  logic [11:0] o_out_coef;
  assign o_in_ready  = sel ? if10.in_ready  : if4.in_ready;
  assign o_out_valid = sel ? if10.out_valid : if4.out_valid;
  assign o_out_last  = sel ? if10.out_last  : if4.out_last;
  assign o_out_coef  = sel ? if10.out_coef  : if4.out_coef;
  assign o_busy      = sel ? busy10 : busy4;
  assign o_done      = sel ? done10 : done4;

  int total = 0;
  int bad   = 0;

  logic [7:0] stim [0:399];
  int  got[$];
  int  n_acc, last_cnt, last_idx, stall_err, done_early, busy_low;
  int  acc1_cyc, acc2_cyc, first_ov;
  bit  timeout, reset_hit, done_after, done_twice, idle_after;

  // round(3329*y/16), worked out by hand
  function automatic int lut4(input int y);
    case (y)
      0: return 0;     1: return 208;   2: return 416;   3: return 624;
      4: return 832;   5: return 1040;  6: return 1248;  7: return 1456;
      8: return 1665;  9: return 1873;  10: return 2081; 11: return 2289;
      12: return 2497; 13: return 2705; 14: return 2913; default: return 3121;
    endcase
  endfunction

  // Coefficient i of the counting stream (byte k = k): low nibble first.
  function automatic int exp_count(input int i);
    int b;
    b = (i / 2) % 256;
    return (i % 2 == 0) ? lut4(b % 16) : lut4(b / 16);
  endfunction

  function automatic int exp_d10(input int i);
    case (i % 4)
      0: return 0;
      1: return 3;
      2: return 1665;
      default: return 3326;
    endcase
  endfunction

  task automatic load_count();
    for (int i = 0; i < 400; i++) stim[i] = 8'(i);
  endtask

  // Drive one polynomial on the selected instance and record what came out.
  task automatic run(input int nbytes, input int gap, input int stall_pct,
                     input int start_at, input int reset_at);
    int bi, cyc, gapcnt;
    bit pulsed, prev_stall;
    logic [11:0] prev_coef;
    logic prev_last;
    got.delete();
    n_acc = 0; last_cnt = 0; last_idx = -1; stall_err = 0; done_early = 0; busy_low = 0;
    acc1_cyc = -1; acc2_cyc = -1; first_ov = -1;
    timeout = 0; reset_hit = 0; done_after = 0; done_twice = 0; idle_after = 0;
    bi = 0; cyc = 0; gapcnt = 0; pulsed = 0; prev_stall = 0; prev_coef = '0; prev_last = 0;
    tb_start = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
    while (got.size() < NC && cyc < 6000 && !reset_hit) begin
      if (reset_at >= 0 && got.size() == reset_at) begin
        rst_n = 1'b0;
        reset_hit = 1;
      end else begin
        tb_start = 1'b0;
        if (start_at >= 0 && !pulsed && got.size() == start_at) begin
          tb_start = 1'b1;
          pulsed = 1;
        end
        tb_in_valid  = (bi < nbytes) && (gapcnt == 0);
        tb_in_byte   = stim[(bi < 400) ? bi : 0];
        tb_out_ready = ($urandom_range(99) >= stall_pct);
        #1;
        if (tb_in_valid) begin
          if (o_in_ready) begin
            if (n_acc == 0) acc1_cyc = cyc;
            if (n_acc == 1) acc2_cyc = cyc;
            n_acc++;
            bi++;
            gapcnt = gap;
          end
        end else if (gapcnt > 0) begin
          gapcnt--;
        end
        if (prev_stall && (!o_out_valid || o_out_coef !== prev_coef || o_out_last !== prev_last))
          stall_err++;
        prev_stall = o_out_valid && !tb_out_ready;
        prev_coef  = o_out_coef;
        prev_last  = o_out_last;
        if (o_out_valid && first_ov < 0) first_ov = cyc;
        if (o_out_valid && tb_out_ready) begin
          if (o_out_last) begin
            last_cnt++;
            last_idx = got.size();
          end
          got.push_back(int'(o_out_coef));
        end
        if (!o_busy) busy_low++;
        if (o_done) done_early++;
        @(negedge clk);
        cyc++;
      end
    end
    tb_start = 1'b0;
    timeout = (cyc >= 6000);
    if (!reset_hit && !timeout) begin
      done_after = o_done && !o_out_valid;
      @(negedge clk);
      done_twice = o_done;
      idle_after = !o_busy && !o_out_valid && !o_in_ready;
    end
    tb_in_valid  = 1'b0;
    tb_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 1'b0; tb_start = 1'b0; tb_in_byte = '0;
    tb_in_valid = 1'b0; tb_out_ready = 1'b0;
    #12;
    total++;
    if ({if4.out_coef, if4.out_valid, if4.out_last, if4.in_ready, busy4, done4} !== 17'd0) begin
      bad++;
      $display("FAIL reset_d4: outputs=%h want 0",
               {if4.out_coef, if4.out_valid, if4.out_last, if4.in_ready, busy4, done4});
    end
    total++;
    if ({if10.out_coef, if10.out_valid, if10.out_last, if10.in_ready, busy10, done10} !== 17'd0) begin
      bad++;
      $display("FAIL reset_d10: outputs=%h want 0",
               {if10.out_coef, if10.out_valid, if10.out_last, if10.in_ready, busy10, done10});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_d4_basic();
    int want;
    int fb;
    sel = 1'b0;
    for (int i = 0; i < 400; i++) stim[i] = 8'h00;
    stim[0] = 8'h10;
    stim[1] = 8'hF8;
    run(140, 0, 0, -1, -1);
    total++;
    if (timeout) begin bad++; $display("FAIL d4_timeout: got=%0d want=256 coefs", got.size()); end
    total++;
    if (got.size() != NC) begin bad++; $display("FAIL d4_count: got=%0d want=256", got.size()); end
    fb = -1;
    for (int i = 0; i < NC; i++) begin
      want = (i == 1) ? 208 : (i == 2) ? 1665 : (i == 3) ? 3121 : 0;
      if (fb < 0 && (i >= got.size() || got[i] !== want)) fb = i;
    end
    total++;
    if (fb >= 0) begin bad++; $display("FAIL d4_seq: first bad index=%0d want value=%0d", fb,
                                       (fb == 1) ? 208 : (fb == 2) ? 1665 : (fb == 3) ? 3121 : 0); end
    total++;
    if (n_acc != 128) begin bad++; $display("FAIL d4_bytes: got=%0d want=128", n_acc); end
    total++;
    if (last_cnt != 1 || last_idx != 255) begin
      bad++; $display("FAIL d4_last: count=%0d idx=%0d want 1/255", last_cnt, last_idx);
    end
    total++;
    if (done_early != 0 || !done_after || done_twice) begin
      bad++; $display("FAIL d4_done: early=%0d after=%0d twice=%0d want 0/1/0",
                      done_early, done_after, done_twice);
    end
    total++;
    if (first_ov - acc1_cyc != 3) begin
      bad++; $display("FAIL d4_latency: got=%0d want=3 negedges", first_ov - acc1_cyc);
    end
    total++;
    if (!idle_after) begin bad++; $display("FAIL d4_idle: got=0 want=1"); end
  endtask

  task automatic test_d4_stall();
    int fb;
    sel = 1'b0;
    load_count();
    run(128, 0, 30, -1, -1);
    fb = -1;
    for (int i = 0; i < NC; i++)
      if (fb < 0 && (i >= got.size() || got[i] !== exp_count(i))) fb = i;
    total++;
    if (fb >= 0 || got.size() != NC) begin
      bad++; $display("FAIL stall_seq: first bad=%0d size=%0d want -1/256", fb, got.size());
    end
    total++;
    if (stall_err != 0) begin bad++; $display("FAIL stall_hold: got=%0d want=0", stall_err); end
    total++;
    if (last_idx != 255 || !done_after) begin
      bad++; $display("FAIL stall_last: idx=%0d done=%0d want 255/1", last_idx, done_after);
    end
  endtask

  task automatic test_d4_gapped();
    int fb;
    sel = 1'b0;
    load_count();
    run(128, 4, 0, -1, -1);
    fb = -1;
    for (int i = 0; i < NC; i++)
      if (fb < 0 && (i >= got.size() || got[i] !== exp_count(i))) fb = i;
    total++;
    if (fb >= 0 || got.size() != NC) begin
      bad++; $display("FAIL gap_seq: first bad=%0d size=%0d want -1/256", fb, got.size());
    end
    total++;
    if (busy_low != 0) begin bad++; $display("FAIL gap_busy: low cycles=%0d want=0", busy_low); end
    total++;
    if (!done_after || done_twice) begin
      bad++; $display("FAIL gap_done: after=%0d twice=%0d want 1/0", done_after, done_twice);
    end
  endtask

  task automatic test_d10_ones();
    int fb;
    sel = 1'b1;
    for (int i = 0; i < 400; i++) stim[i] = 8'hFF;
    run(330, 0, 0, -1, -1);
    fb = -1;
    for (int i = 0; i < NC; i++)
      if (fb < 0 && (i >= got.size() || got[i] !== 3326)) fb = i;
    total++;
    if (fb >= 0 || got.size() != NC) begin
      bad++; $display("FAIL d10_ones: first bad=%0d size=%0d want -1/256", fb, got.size());
    end
    total++;
    if (n_acc != 320) begin bad++; $display("FAIL d10_bytes: got=%0d want=320", n_acc); end
    total++;
    if (!idle_after) begin bad++; $display("FAIL d10_idle: got=0 want=1"); end
  endtask

  task automatic test_d10_pattern();
    int fb;
    logic [7:0] pat [0:4];
    sel = 1'b1;
    pat[0] = 8'h00; pat[1] = 8'h04; pat[2] = 8'h00; pat[3] = 8'hE0; pat[4] = 8'hFF;
    for (int i = 0; i < 400; i++) stim[i] = pat[i % 5];
    run(320, 0, 0, -1, -1);
    fb = -1;
    for (int i = 0; i < NC; i++)
      if (fb < 0 && (i >= got.size() || got[i] !== exp_d10(i))) fb = i;
    total++;
    if (fb >= 0 || got.size() != NC) begin
      bad++; $display("FAIL d10_seq: first bad=%0d size=%0d want -1/256", fb, got.size());
    end
    total++;
    if (first_ov - acc2_cyc != 3) begin
      bad++; $display("FAIL d10_latency: got=%0d want=3 negedges", first_ov - acc2_cyc);
    end
  endtask

  task automatic test_start_and_reset();
    int fb;
    sel = 1'b0;
    load_count();
    run(128, 0, 0, 100, 150);
    fb = -1;
    for (int i = 0; i < 150; i++)
      if (fb < 0 && (i >= got.size() || got[i] !== exp_count(i))) fb = i;
    total++;
    if (fb >= 0 || got.size() != 150) begin
      bad++; $display("FAIL restart_ignored: first bad=%0d size=%0d want -1/150", fb, got.size());
    end
    total++;
    if (busy_low != 0) begin bad++; $display("FAIL restart_busy: low cycles=%0d want=0", busy_low); end
    #1;
    total++;
    if ({if4.out_coef, if4.out_valid, if4.out_last, if4.in_ready, busy4, done4} !== 17'd0) begin
      bad++;
      $display("FAIL midreset_out: outputs=%h want 0",
               {if4.out_coef, if4.out_valid, if4.out_last, if4.in_ready, busy4, done4});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(128, 0, 0, -1, -1);
    fb = -1;
    for (int i = 0; i < NC; i++)
      if (fb < 0 && (i >= got.size() || got[i] !== exp_count(i))) fb = i;
    total++;
    if (fb >= 0 || got.size() != NC) begin
      bad++; $display("FAIL fresh_seq: first bad=%0d size=%0d want -1/256", fb, got.size());
    end
    total++;
    if (n_acc != 128 || !done_after) begin
      bad++; $display("FAIL fresh_end: bytes=%0d done=%0d want 128/1", n_acc, done_after);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_d4_basic();
    test_d4_stall();
    test_d4_gapped();
    test_d10_ones();
    test_d10_pattern();
    test_start_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
